// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Round-robin arbiter sharing one pipelined Wishbone slave between
// NUM_MASTERS masters. A master holds the bus for its whole cycle (cyc). The
// arbiter limits the number of outstanding strobes and aborts a hung cycle
// with err.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-low reset
//   m_cyc_i/m_stb_i/m_we_i  per-master request bits
//   m_adr_i/m_dat_i/m_sel_i flattened per-master fields, master k at slice k
//   m_dat_o                 read data broadcast to all masters
//   m_ack_o/m_err_o         response, routed to the granted master only
//   m_stall_o               per-master stall
//   grant_o                 one-hot current grant (debug)
//   s_*                     single slave port
//
// state | meaning
// IDLE  | no owner, round-robin pick among m_cyc_i
// GRANT | master gidx owns the slave, requests muxed through
// ABORT | watchdog fired, slave cut off until owner drops cyc
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int GRANULE         = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 64,
    localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
    output logic [DATA_WIDTH-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [NUM_MASTERS-1:0]            m_stall_o,
    output logic [NUM_MASTERS-1:0]            grant_o,
    output logic                              s_cyc_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_adr_o,
    output logic [DATA_WIDTH-1:0]             s_dat_o,
    output logic [SEL_WIDTH-1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]             s_dat_i,
    input  logic                              s_ack_i,
    input  logic                              s_err_i,
    input  logic                              s_stall_i
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] ABORT = 2'd2;

    logic [1:0]             state;
    logic [IDX_W-1:0]       gidx;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       rr_ptr;
    logic [OUT_W-1:0]       outstanding;
    logic [WD_W-1:0]        wdog;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W:0]         pick_sum;
    logic [IDX_W-1:0]       next_ptr;
    logic                   cyc_g;
    logic                   stb_g;
    logic                   in_grant;
    logic                   full;
    logic                   resp;
    logic                   accept;
    logic                   retire;
    logic                   wd_hit;

    // Round-robin scan starting at rr_ptr, wrapping modulo NUM_MASTERS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            pick_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (pick_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
                pick_sum = pick_sum - (IDX_W+1)'(NUM_MASTERS);
            end
            if (!pick_found && m_cyc_i[pick_sum[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pick_sum[IDX_W-1:0];
            end
        end
    end

    assign next_ptr = (gidx == IDX_W'(NUM_MASTERS - 1)) ? '0 : gidx + IDX_W'(1);

    // Slave-side request mux, driven from the registered grant index.
    always_comb begin
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        cyc_g   = 1'b0;
        stb_g   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gidx == IDX_W'(k)) begin
                cyc_g   = m_cyc_i[k];
                stb_g   = m_stb_i[k];
                s_we_o  = m_we_i[k];
                s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                s_sel_o = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
            end
        end
    end

    assign in_grant = (state == GRANT);
    assign full     = (outstanding == OUT_W'(MAX_OUTSTANDING));
    assign resp     = s_ack_i | s_err_i;
    assign s_cyc_o  = in_grant & cyc_g;
    // Strobe is also qualified by cyc so a master that drops cyc with stb
    // still high cannot leak a strobe onto the slave.
    assign s_stb_o  = in_grant & cyc_g & stb_g & ~full;
    assign accept   = s_stb_o & ~s_stall_i;
    // Acks with nothing outstanding are forwarded but must not underflow.
    assign retire   = in_grant & resp & (outstanding != '0);
    // A real response arriving on the terminal cycle wins over the abort.
    assign wd_hit   = in_grant & cyc_g & (outstanding != '0) & ~resp
                    & (wdog == WD_W'(TIMEOUT));

    assign m_dat_o  = s_dat_i;
    assign grant_o  = grant;

    // Master-side response/stall routing. Stalls are forced low while in
    // reset so that every output is quiet during reset.
    always_comb begin
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if ((state != IDLE) && (gidx == IDX_W'(k))) begin
                m_ack_o[k]   = s_cyc_o & s_ack_i;
                m_err_o[k]   = (s_cyc_o & s_err_i) | wd_hit;
                m_stall_o[k] = rst_i & ((state == ABORT) | s_stall_i | full);
            end else begin
                m_stall_o[k] = rst_i & m_cyc_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            gidx        <= '0;
            grant       <= '0;
            rr_ptr      <= '0;
            outstanding <= '0;
            wdog        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    outstanding <= '0;
                    wdog        <= '0;
                    if (pick_found) begin
                        state <= GRANT;
                        gidx  <= pick_idx;
                        grant <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
                    end
                end
                GRANT: begin
                    if (!cyc_g) begin
                        state       <= IDLE;
                        grant       <= '0;
                        outstanding <= '0;
                        wdog        <= '0;
                        rr_ptr      <= next_ptr;
                    end else if (wd_hit) begin
                        state       <= ABORT;
                        outstanding <= '0;
                        wdog        <= '0;
                    end else begin
                        if (accept && !retire) begin
                            outstanding <= outstanding + OUT_W'(1);
                        end else if (!accept && retire) begin
                            outstanding <= outstanding - OUT_W'(1);
                        end
                        if (resp || (outstanding == '0)) begin
                            wdog <= '0;
                        end else if (wdog != WD_W'(TIMEOUT)) begin
                            wdog <= wdog + WD_W'(1);
                        end
                    end
                end
                ABORT: begin
                    outstanding <= '0;
                    wdog        <= '0;
                    if (!cyc_g) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter (2 masters, 16-bit address, 32-bit data).
// Stimulus pushes expected slave-side requests and master-side responses into
// queues; a negedge monitor pops and compares whenever the DUT presents an
// accepted strobe or an ack/err. Control timing is checked inline.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic [NM-1:0]   m_cyc_i = '0;
    logic [NM-1:0]   m_stb_i = '0;
    logic [NM-1:0]   m_we_i = '0;
    logic [NM*AW-1:0] m_adr_i = '0;
    logic [NM*DW-1:0] m_dat_i = '0;
    logic [NM*SW-1:0] m_sel_i = '0;
    logic [DW-1:0]   m_dat_o;
    logic [NM-1:0]   m_ack_o;
    logic [NM-1:0]   m_err_o;
    logic [NM-1:0]   m_stall_o;
    logic [NM-1:0]   grant_o;
    logic            s_cyc_o;
    logic            s_stb_o;
    logic            s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i = 32'hCAFEF00D;
    logic            s_ack_i = 1'b0;
    logic            s_err_i = 1'b0;
    logic            s_stall_i = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [52:0] exp_req_q[$];
    logic [35:0] exp_resp_q[$];
    logic [52:0] exp_req;
    logic [35:0] exp_resp;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8),
        .MAX_OUTSTANDING(4), .TIMEOUT(64)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_stall_o(m_stall_o), .grant_o(grant_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_stall_i(s_stall_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
        if (k == 0) begin
            m_cyc_i[0] = cyc; m_stb_i[0] = stb; m_we_i[0] = we;
            m_adr_i[AW-1:0] = adr; m_dat_i[DW-1:0] = dat; m_sel_i[SW-1:0] = sel;
        end else begin
            m_cyc_i[1] = cyc; m_stb_i[1] = stb; m_we_i[1] = we;
            m_adr_i[2*AW-1:AW] = adr; m_dat_i[2*DW-1:DW] = dat; m_sel_i[2*SW-1:SW] = sel;
        end
    endtask

    task automatic push_req(input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        exp_req_q.push_back({we, adr, dat, sel});
    endtask

    task automatic push_resp(input logic [1:0] ack, input logic [1:0] err, input logic [DW-1:0] dat);
        exp_resp_q.push_back({ack, err, dat});
    endtask

    // Monitor: compares every accepted strobe and every response.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (s_stb_o && !s_stall_i) begin
                if (exp_req_q.size() == 0) begin
                    check("req_unexpected", 64'(exp_req_q.size()), 64'd1);
                end else begin
                    exp_req = exp_req_q.pop_front();
                    check("slave_req", 64'({s_we_o, s_adr_o, s_dat_o, s_sel_o}), 64'(exp_req));
                end
            end
            if ((|m_ack_o) || (|m_err_o)) begin
                if (exp_resp_q.size() == 0) begin
                    check("resp_unexpected", 64'(exp_resp_q.size()), 64'd1);
                end else begin
                    exp_resp = exp_resp_q.pop_front();
                    check("master_resp", 64'({m_ack_o, m_err_o, m_dat_o}), 64'(exp_resp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int early;

        // reset state
        step(); step();
        @(negedge clk_i);
        check("rst_scyc", 64'(s_cyc_o), 64'd0);
        check("rst_sstb", 64'(s_stb_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_ackerr", 64'({m_ack_o, m_err_o, m_stall_o}), 64'd0);
        step();
        rst_i = 1'b1;
        step();

        // m0 single write
        set_m(0, 1, 1, 1, 16'h0004, 32'hDEADBEEF, 4'hF);
        push_req(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF);
        @(negedge clk_i);
        check("latency_scyc_low", 64'(s_cyc_o), 64'd0);
        check("idle_stall_m0", 64'(m_stall_o), 64'd1);
        step();
        @(negedge clk_i);
        check("scyc_rise", 64'(s_cyc_o), 64'd1);
        check("grant_m0", 64'(grant_o), 64'd1);
        step();
        m_stb_i[0] = 1'b0;
        s_ack_i = 1'b1;
        push_resp(2'b01, 2'b00, 32'hCAFEF00D);
        @(negedge clk_i);
        check("ack_m0_only", 64'(m_ack_o), 64'd1);
        step();
        s_ack_i = 1'b0;
        m_cyc_i[0] = 1'b0;
        @(negedge clk_i);
        check("release_scyc", 64'(s_cyc_o), 64'd0);
        step();

        // round robin: pointer now at m1
        set_m(0, 1, 0, 0, 16'h0000, 32'h0, 4'h0);
        set_m(1, 1, 0, 0, 16'h0000, 32'h0, 4'h0);
        @(negedge clk_i);
        check("idle_stall_both", 64'(m_stall_o), 64'd3);
        step();
        @(negedge clk_i);
        check("rr_m1", 64'(grant_o), 64'd2);
        check("rr_m1_stall", 64'(m_stall_o), 64'd1);
        step();
        m_cyc_i[1] = 1'b0;
        step();
        @(negedge clk_i);
        check("rr_idle", 64'(grant_o), 64'd0);
        m_cyc_i[1] = 1'b1;
        step();
        @(negedge clk_i);
        check("rr_m0", 64'(grant_o), 64'd1);
        check("lock_stall", 64'(m_stall_o), 64'd2);

        // outstanding limit
        step();
        set_m(0, 1, 1, 0, 16'h0010, 32'h0, 4'hF); push_req(1'b0, 16'h0010, 32'h0, 4'hF);
        step();
        m_adr_i[AW-1:0] = 16'h0014; push_req(1'b0, 16'h0014, 32'h0, 4'hF);
        step();
        m_adr_i[AW-1:0] = 16'h0018; push_req(1'b0, 16'h0018, 32'h0, 4'hF);
        step();
        m_adr_i[AW-1:0] = 16'h001C; push_req(1'b0, 16'h001C, 32'h0, 4'hF);
        step();
        m_adr_i[AW-1:0] = 16'h0020;
        @(negedge clk_i);
        check("full_stb", 64'(s_stb_o), 64'd0);
        check("full_stall", 64'(m_stall_o[0]), 64'd1);
        step();
        @(negedge clk_i);
        check("full_hold", 64'(s_stb_o), 64'd0);
        step();
        s_ack_i = 1'b1;
        push_resp(2'b01, 2'b00, 32'hCAFEF00D);
        @(negedge clk_i);
        check("full_ack_cycle_stb", 64'(s_stb_o), 64'd0);
        step();
        s_ack_i = 1'b0;
        push_req(1'b0, 16'h0020, 32'h0, 4'hF);
        @(negedge clk_i);
        check("refill_stb", 64'(s_stb_o), 64'd1);
        step();
        m_adr_i[AW-1:0] = 16'h0024;
        @(negedge clk_i);
        check("refull_stb", 64'(s_stb_o), 64'd0);
        step();
        m_cyc_i = 2'b00;
        m_stb_i = 2'b00;
        step();
        s_ack_i = 1'b1;
        @(negedge clk_i);
        check("late_ack_dropped", 64'(m_ack_o), 64'd0);
        step();
        s_ack_i = 1'b0;

        // watchdog
        set_m(0, 1, 1, 1, 16'h0040, 32'h12345678, 4'h3);
        push_req(1'b1, 16'h0040, 32'h12345678, 4'h3);
        step();
        step();
        m_stb_i[0] = 1'b0;
        early = 0;
        for (int i = 0; i < 63; i++) begin
            step();
            @(negedge clk_i);
            if (m_err_o != 2'b00) early++;
        end
        check("wd_no_early_err", 64'(early), 64'd0);
        push_resp(2'b00, 2'b01, 32'hCAFEF00D);
        step();
        @(negedge clk_i);
        check("wd_err", 64'(m_err_o), 64'd1);
        step();
        @(negedge clk_i);
        check("wd_pulse_1cyc", 64'(m_err_o), 64'd0);
        check("abort_scyc", 64'(s_cyc_o), 64'd0);
        check("abort_stall", 64'(m_stall_o[0]), 64'd1);
        step(); step();
        @(negedge clk_i);
        check("abort_hold", 64'(s_cyc_o), 64'd0);
        step();
        m_cyc_i[0] = 1'b0;
        step();

        // slave error on m1 read
        set_m(1, 1, 1, 0, 16'hFFF0, 32'h0, 4'hF);
        push_req(1'b0, 16'hFFF0, 32'h0, 4'hF);
        step();
        @(negedge clk_i);
        check("err_grant_m1", 64'(grant_o), 64'd2);
        step();
        m_stb_i[1] = 1'b0;
        s_err_i = 1'b1;
        push_resp(2'b00, 2'b10, 32'hCAFEF00D);
        @(negedge clk_i);
        check("err_m1", 64'(m_err_o), 64'd2);
        step();
        s_err_i = 1'b0;
        @(negedge clk_i);
        check("err_grant_hold", 64'(grant_o), 64'd2);
        step();
        m_stb_i[1] = 1'b1; m_adr_i[2*AW-1:AW] = 16'h00A0; push_req(1'b0, 16'h00A0, 32'h0, 4'hF);
        step();
        m_adr_i[2*AW-1:AW] = 16'h00A4; push_req(1'b0, 16'h00A4, 32'h0, 4'hF);
        step();
        m_adr_i[2*AW-1:AW] = 16'h00A8; push_req(1'b0, 16'h00A8, 32'h0, 4'hF);
        step();
        m_adr_i[2*AW-1:AW] = 16'h00AC; push_req(1'b0, 16'h00AC, 32'h0, 4'hF);
        @(negedge clk_i);
        check("post_err_4th_stb", 64'(s_stb_o), 64'd1);
        step();
        m_adr_i[2*AW-1:AW] = 16'h00B0;
        @(negedge clk_i);
        check("post_err_full", 64'(s_stb_o), 64'd0);
        step();
        m_stb_i[1] = 1'b0;
        s_ack_i = 1'b1;
        push_resp(2'b10, 2'b00, 32'hCAFEF00D);
        step();
        push_resp(2'b10, 2'b00, 32'hCAFEF00D);
        step();
        s_ack_i = 1'b0;

        // async reset mid-GRANT with two outstanding
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_scyc_stb", 64'({s_cyc_o, s_stb_o}), 64'd0);
        check("arst_ack_err", 64'({m_ack_o, m_err_o}), 64'd0);
        check("arst_stall", 64'(m_stall_o), 64'd0);
        check("arst_grant", 64'(grant_o), 64'd0);
        set_m(0, 1, 0, 0, 16'h0000, 32'h0, 4'h0);
        step();
        rst_i = 1'b1;
        step();
        @(negedge clk_i);
        check("post_reset_m0", 64'(grant_o), 64'd1);
        check("post_reset_stall", 64'(m_stall_o), 64'd2);
        step();
        m_cyc_i = 2'b00;
        step(); step();

        check("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        check("resp_queue_empty", 64'(exp_resp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
